// File: rtl/quant_block.sv
// quant_block: encoder-side quantizer dividing an 8x8 block by a per-channel table, rounding half away from zero.
// Ports:
//   clock, reset_n        clock (rising edge) and asynchronous active-low reset
//   blockIn, ch, valid_in input block, its channel, and valid; ready_in is high while idle
//   quant_packet          quantization tables and channel map, snapshotted on acceptance
//   blockOut, chOut       quantized block and its channel, valid while valid_out is high
//   valid_out, ready_out  output handshake
`ifndef CH
`define CH 3
`endif

package quant_pkg;
  localparam int CH_W = $clog2(`CH + 1);
  localparam int NT = 1 << CH_W;
  localparam int TAB_W = 8;
  typedef struct packed {
    logic [7:0][7:0][TAB_W-1:0] tab;
  } qtab_t;
  typedef struct packed {
    qtab_t [NT-1:0] tabs;
    logic [NT-1:0][CH_W-1:0] map;
  } QUANT_PACKET;
endpackage

module quant_block
  import quant_pkg::*;
#(
  parameter int COEF_W = 12,
  parameter int Q_W = TAB_W
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic [7:0][7:0][COEF_W-1:0] blockIn,
  input  logic                        valid_in,
  output logic                        ready_in,
  input  logic [CH_W-1:0]             ch,
  input  QUANT_PACKET                 quant_packet,
  output logic [7:0][7:0][COEF_W-1:0] blockOut,
  output logic                        valid_out,
  input  logic                        ready_out,
  output logic [CH_W-1:0]             chOut
);
  localparam int CNT_W = $clog2(COEF_W);
  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;
  state_t state_q, state_d;
  logic [63:0][COEF_W-1:0] coef_q, coef_d, blk_q, blk_d;
  logic [63:0][TAB_W-1:0] tab_q, tab_d;
  logic [CH_W-1:0] ch_q, ch_d;
  logic [5:0] k_q, k_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [Q_W-1:0] rem_q, rem_d;
  logic [COEF_W-1:0] quo_q, quo_d;
  logic [COEF_W-1:0] x, ax, num, num_sh, quo_nx, res;
  logic [Q_W-1:0] qe;
  logic [Q_W:0] rem_sh, rem_sub;
  logic neg, ge, last;
  // One restoring-division step on the current coefficient; the numerator is
  // recomputed each cycle from the held operands and shifted to expose the next bit.
  always_comb begin
    x = coef_q[k_q];
    neg = x[COEF_W-1];
    ax = neg ? -x : x;
    qe = (tab_q[k_q] == '0) ? Q_W'(1) : Q_W'(tab_q[k_q]);
    num = ax + COEF_W'(qe >> 1);
    num_sh = num << cnt_q;
    rem_sh = {rem_q, num_sh[COEF_W-1]};
    rem_sub = rem_sh - {1'b0, qe};
    ge = rem_sh >= {1'b0, qe};
    quo_nx = {quo_q[COEF_W-2:0], ge};
    res = neg ? -quo_nx : quo_nx;
    last = cnt_q == CNT_W'(COEF_W - 1);
  end
  always_comb begin
    state_d = state_q;
    coef_d = coef_q;
    tab_d = tab_q;
    ch_d = ch_q;
    blk_d = blk_q;
    k_d = k_q;
    cnt_d = cnt_q;
    rem_d = rem_q;
    quo_d = quo_q;
    if (state_q == IDLE && valid_in) begin
      coef_d = blockIn;
      tab_d = quant_packet.tabs[quant_packet.map[ch]].tab;
      ch_d = ch;
      k_d = '0;
      cnt_d = '0;
      rem_d = '0;
      quo_d = '0;
      state_d = DIV;
    end else if (state_q == DIV) begin
      cnt_d = last ? '0 : cnt_q + 1'b1;
      rem_d = last ? '0 : (ge ? rem_sub[Q_W-1:0] : rem_sh[Q_W-1:0]);
      quo_d = last ? '0 : quo_nx;
      if (last) begin
        blk_d[k_q] = res;
        k_d = k_q + 6'd1;
        state_d = (k_q == 6'd63) ? DONE : DIV;
      end
    end else if (state_q == DONE && ready_out) begin
      state_d = IDLE;
    end
  end
  always_comb begin
    ready_in = state_q == IDLE;
    valid_out = state_q == DONE;
  end
  assign blockOut = blk_q;
  assign chOut = ch_q;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      coef_q <= '0;
      tab_q <= '0;
      ch_q <= '0;
      blk_q <= '0;
      k_q <= '0;
      cnt_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
    end else begin
      state_q <= state_d;
      coef_q <= coef_d;
      tab_q <= tab_d;
      ch_q <= ch_d;
      blk_q <= blk_d;
      k_q <= k_d;
      cnt_q <= cnt_d;
      rem_q <= rem_d;
      quo_q <= quo_d;
    end
  end
endmodule
